// File: rtl/iob_ethmac_mem_arb.sv
// Two-master IOb arbiter: merges the Ethernet MAC master (port 0) and a second
// system master (port 1) onto one memory port with round-robin fairness.
module iob_ethmac_mem_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s0_valid,
  input  logic [ADDR_W-1:0]   s0_addr,
  input  logic [DATA_W-1:0]   s0_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb,
  output logic [DATA_W-1:0]   s0_rdata,
  output logic                s0_ready,
  input  logic                s1_valid,
  input  logic [ADDR_W-1:0]   s1_addr,
  input  logic [DATA_W-1:0]   s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  output logic [DATA_W-1:0]   s1_rdata,
  output logic                s1_ready,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic                grant,
  output logic                dbg_state
);

  // Handshake (all ports): the requester holds valid and payload stable until
  // ready; a transfer completes in the cycle valid=1 and ready=1, and read data
  // is valid in that same cycle.

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state;
  logic   last;
  logic   pick;

  // Lone requester wins; on contention the port not served last wins.
  always_comb begin
    pick = s1_valid & (~s0_valid | ~last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      m_valid <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_wstrb <= '0;
      grant   <= 1'b0;
      last    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (s0_valid || s1_valid) begin
            state   <= BUSY;
            m_valid <= 1'b1;
            grant   <= pick;
            m_addr  <= pick ? s1_addr  : s0_addr;
            m_wdata <= pick ? s1_wdata : s0_wdata;
            m_wstrb <= pick ? s1_wstrb : s0_wstrb;
          end
        end
        BUSY: begin
          if (m_ready) begin
            state   <= IDLE;
            m_valid <= 1'b0;
            last    <= grant;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Responses arriving while IDLE are stale and never reach a master.
  assign s0_ready  = m_ready & (state == BUSY) & ~grant;
  assign s1_ready  = m_ready & (state == BUSY) & grant;
  assign s0_rdata  = m_rdata;
  assign s1_rdata  = m_rdata;
  assign dbg_state = (state == BUSY);

endmodule

// File: tb/tb_iob_ethmac_mem_arb.sv
// Bench for iob_ethmac_mem_arb: per-cycle vector table plus hand-written
// sequences for round-robin contention and asynchronous reset.
module tb_iob_ethmac_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_valid, s1_valid, m_ready;
  logic [31:0] s0_addr, s0_wdata, s1_addr, s1_wdata, m_rdata;
  logic [3:0]  s0_wstrb, s1_wstrb;
  logic [31:0] s0_rdata, s1_rdata, m_addr, m_wdata;
  logic        s0_ready, s1_ready, m_valid, grant, dbg_state;
  logic [3:0]  m_wstrb;

  int n_checks = 0;
  int n_pass   = 0;

  // clock / reset
  always #5 clk = ~clk;

  iob_ethmac_mem_arb #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
    .s0_rdata(s0_rdata), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
    .s1_rdata(s1_rdata), .s1_ready(s1_ready),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .grant(grant), .dbg_state(dbg_state)
  );

  typedef struct {
    logic        s0_valid;
    logic [31:0] s0_addr, s0_wdata;
    logic [3:0]  s0_wstrb;
    logic        s1_valid;
    logic [31:0] s1_addr, s1_wdata;
    logic [3:0]  s1_wstrb;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        e_m_valid;
    logic [31:0] e_m_addr, e_m_wdata;
    logic [3:0]  e_m_wstrb;
    logic        e_s0_ready, e_s1_ready, e_grant, e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(
    input logic s0v, input logic [31:0] s0a, input logic [31:0] s0d, input logic [3:0] s0s,
    input logic s1v, input logic [31:0] s1a, input logic [31:0] s1d, input logic [3:0] s1s,
    input logic mr, input logic [31:0] mrd,
    input logic emv, input logic [31:0] ema, input logic [31:0] emd, input logic [3:0] ems,
    input logic e0r, input logic e1r, input logic eg, input logic eb);
    vec_t r;
    r.s0_valid = s0v; r.s0_addr = s0a; r.s0_wdata = s0d; r.s0_wstrb = s0s;
    r.s1_valid = s1v; r.s1_addr = s1a; r.s1_wdata = s1d; r.s1_wstrb = s1s;
    r.m_ready = mr; r.m_rdata = mrd;
    r.e_m_valid = emv; r.e_m_addr = ema; r.e_m_wdata = emd; r.e_m_wstrb = ems;
    r.e_s0_ready = e0r; r.e_s1_ready = e1r; r.e_grant = eg; r.e_busy = eb;
    return r;
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // driver tasks
  task automatic idle_inputs();
    s0_valid = 0; s0_addr = 0; s0_wdata = 0; s0_wstrb = 0;
    s1_valid = 0; s1_addr = 0; s1_wdata = 0; s1_wstrb = 0;
    m_ready = 0; m_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    m_ready = 1'b1;
    #1;
    check("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_m_wdata", m_wdata, 32'd0);
    check("rst_m_wstrb", {28'b0, m_wstrb}, 32'd0);
    check("rst_grant", {31'b0, grant}, 32'd0);
    check("rst_readies", {30'b0, s1_ready, s0_ready}, 32'd0);
    check("rst_state", {31'b0, dbg_state}, 32'd0);
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic apply_vec(input int idx, input vec_t t);
    string tag;
    tag = $sformatf("vec%0d", idx);
    s0_valid = t.s0_valid; s0_addr = t.s0_addr; s0_wdata = t.s0_wdata; s0_wstrb = t.s0_wstrb;
    s1_valid = t.s1_valid; s1_addr = t.s1_addr; s1_wdata = t.s1_wdata; s1_wstrb = t.s1_wstrb;
    m_ready = t.m_ready; m_rdata = t.m_rdata;
    #1;
    check({tag, "_m_valid"}, {31'b0, m_valid}, {31'b0, t.e_m_valid});
    check({tag, "_m_addr"}, m_addr, t.e_m_addr);
    check({tag, "_m_wdata"}, m_wdata, t.e_m_wdata);
    check({tag, "_m_wstrb"}, {28'b0, m_wstrb}, {28'b0, t.e_m_wstrb});
    check({tag, "_s0_ready"}, {31'b0, s0_ready}, {31'b0, t.e_s0_ready});
    check({tag, "_s1_ready"}, {31'b0, s1_ready}, {31'b0, t.e_s1_ready});
    check({tag, "_grant"}, {31'b0, grant}, {31'b0, t.e_grant});
    check({tag, "_state"}, {31'b0, dbg_state}, {31'b0, t.e_busy});
    if (t.e_s0_ready) check({tag, "_s0_rdata"}, s0_rdata, t.m_rdata);
    if (t.e_s1_ready) check({tag, "_s1_rdata"}, s1_rdata, t.m_rdata);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Wait (at negedges) for m_valid, bounded; a timeout counts as a failure.
  task automatic wait_mvalid(input string name);
    int n;
    n = 0;
    while (!m_valid && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (m_valid) n_pass++;
    else $display("FAIL %s: m_valid timeout, got 0, expected 1 within 20 cycles", name);
  endtask

  task automatic complete(input logic [31:0] data);
    m_ready = 1'b1; m_rdata = data;
    @(posedge clk);
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  initial begin
    idle_inputs();
    do_reset();

    //      s0: v  addr          wdata         strb  s1: v  addr   wdata         strb  mr rdata
    //      exp: mv addr         wdata         strb  r0 r1 g busy
    vecs.push_back(v(1, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 0,                0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 0,                1, 32'h1000, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 0,                1, 32'h1000, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 0,                1, 32'h1000, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, 32'h1000, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF,     1, 32'h1000, 0, 0, 1, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                       0, 32'h1000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 32'h20, 32'h12345678, 4'hF, 0, 0,    0, 32'h1000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 32'h20, 32'h12345678, 4'hF, 0, 0,    1, 32'h20, 32'h12345678, 4'hF, 0, 0, 1, 1));
    vecs.push_back(v(0, 0, 0, 0, 1, 32'h20, 32'h12345678, 4'hF, 1, 32'hCAFEF00D, 1, 32'h20, 32'h12345678, 4'hF, 0, 1, 1, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                       0, 32'h20, 32'h12345678, 4'hF, 0, 0, 1, 0));
    vecs.push_back(v(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 32'h20, 32'h12345678, 4'hF, 0, 0, 1, 0));
    vecs.push_back(v(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0,                 1, 32'h100, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, 32'h200, 32'h55, 4'hF, 1, 32'h44, 32'h66, 4'h3, 0, 0, 1, 32'h100, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, 32'h200, 32'h55, 4'hF, 1, 32'h44, 32'h66, 4'h3, 1, 32'hA5A5A5A5, 1, 32'h100, 0, 0, 1, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77,                  0, 32'h100, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                       0, 32'h100, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) apply_vec(i, vecs[i]);
    idle_inputs();

    // Contention out of reset: grants must alternate 0,1,0,1.
    do_reset();
    s0_valid = 1; s0_addr = 32'hA0;
    s1_valid = 1; s1_addr = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      logic exp_g;
      exp_g = (i % 2) == 1;
      wait_mvalid($sformatf("rr%0d_wait", i));
      check($sformatf("rr%0d_grant", i), {31'b0, grant}, {31'b0, exp_g});
      check($sformatf("rr%0d_m_addr", i), m_addr, exp_g ? 32'hB0 : 32'hA0);
      m_ready = 1; m_rdata = 32'h100 + i;
      #1;
      check($sformatf("rr%0d_s0_ready", i), {31'b0, s0_ready}, {31'b0, ~exp_g});
      check($sformatf("rr%0d_s1_ready", i), {31'b0, s1_ready}, {31'b0, exp_g});
      @(posedge clk);
      @(negedge clk);
      m_ready = 0;
      check($sformatf("rr%0d_bubble", i), {31'b0, m_valid}, 32'd0);
    end
    s0_valid = 0; s1_valid = 0;
    @(posedge clk);
    @(negedge clk);

    // Serve port 0 so port 1 would win the next contention without a reset.
    s0_valid = 1; s0_addr = 32'h300;
    wait_mvalid("pre_rst_p0_wait");
    complete(32'h1);
    s0_valid = 0;
    @(posedge clk);
    @(negedge clk);
    s1_valid = 1; s1_addr = 32'h400;
    wait_mvalid("pre_rst_p1_wait");
    check("pre_rst_grant", {31'b0, grant}, 32'd1);
    s1_valid = 0;

    // Asynchronous reset in the middle of the cycle, away from any clock edge.
    #2 rst = 1;
    #1;
    check("async_rst_m_valid", {31'b0, m_valid}, 32'd0);
    check("async_rst_state", {31'b0, dbg_state}, 32'd0);
    check("async_rst_m_addr", m_addr, 32'd0);
    #1 rst = 0;
    @(negedge clk);
    m_ready = 1; m_rdata = 32'hBAD0BAD0;
    #1;
    check("late_resp_s0_ready", {31'b0, s0_ready}, 32'd0);
    check("late_resp_s1_ready", {31'b0, s1_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    m_ready = 0;
    check("late_resp_state", {31'b0, dbg_state}, 32'd0);
    check("late_resp_m_valid", {31'b0, m_valid}, 32'd0);

    s0_valid = 1; s0_addr = 32'h500;
    s1_valid = 1; s1_addr = 32'h600;
    wait_mvalid("post_rst_wait");
    check("post_rst_grant", {31'b0, grant}, 32'd0);
    check("post_rst_m_addr", m_addr, 32'h500);
    s1_valid = 0;
    m_ready = 1; m_rdata = 32'h2;
    #1;
    check("post_rst_s0_ready", {31'b0, s0_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
